// File: rtl/spi_mem_sequencer.sv
// SPI memory frame sequencer: turns single-byte save-RAM requests into WREN/WRITE/READ frames
// and feeds the bit shifter one byte at a time over a start/done handshake.
module spi_mem_sequencer #(
   parameter int unsigned ADDR_W    = 17,
   parameter logic [7:0]  CMD_READ  = 8'h03,
   parameter logic [7:0]  CMD_WRITE = 8'h02,
   parameter logic [7:0]  CMD_WREN  = 8'h06,
   parameter int unsigned CS_GAP    = 2,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_wdata,
   output logic              rsp_valid,
   output logic [7:0]        rsp_rdata,
   output logic              rsp_err,
   output logic              cs_n,
   output logic              sh_start,
   output logic [7:0]        sh_tx,
   input  logic              sh_done,
   input  logic [7:0]        sh_rx
);

   localparam int unsigned TimerMax = (TIMEOUT > CS_GAP) ? TIMEOUT : CS_GAP;
   localparam int unsigned TimerW   = $clog2(TimerMax + 1);

   typedef enum logic [3:0] {
      StIdle, StWrenSel, StWrenByte, StGap, StSel, StCmd, StA2, StA1, StA0, StData, StDesel
   } state_e;

   state_e            state_q, state_d, byte_next;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              first_q, first_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              write_q, write_d;
   logic [23:0]       addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        rdata_q, rdata_d;

   function automatic logic is_byte(state_e s);
      return s inside {StWrenByte, StCmd, StA2, StA1, StA0, StData};
   endfunction

   always_comb begin
      byte_next = StDesel;
      case (state_q)
         StWrenByte: byte_next = StGap;
         StCmd:      byte_next = StA2;
         StA2:       byte_next = StA1;
         StA1:       byte_next = StA0;
         StA0:       byte_next = StData;
         default:    byte_next = StDesel;
      endcase
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      err_d   = err_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         StIdle: begin
            if (req_valid && ready_q) begin
               write_d = req_write;
               addr_d  = 24'(req_addr);
               wdata_d = req_wdata;
               err_d   = 1'b0;
               state_d = req_write ? StWrenSel : StSel;
            end
         end
         StWrenSel: state_d = StWrenByte;
         StGap: begin
            if (timer_q == TimerW'(CS_GAP - 1)) state_d = StSel;
            else timer_d = timer_q + 1'b1;
         end
         StSel: state_d = StCmd;
         StWrenByte, StCmd, StA2, StA1, StA0, StData: begin
            // sh_done on the sh_start cycle is illegal from the shifter and is ignored
            if (!first_q) begin
               if (sh_done) begin
                  if (state_q == StData && !write_q) rdata_d = sh_rx;
                  state_d = byte_next;
               end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = StDesel;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Timer restarts on every state change, which covers each sh_start and GAP entry
      if (state_d != state_q) timer_d = '0;
      first_d = (state_d != state_q) && is_byte(state_d);
      ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         timer_q <= '0;
         first_q <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         first_q <= first_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      req_ready = ready_q;
      sh_start  = first_q;
      cs_n      = state_q inside {StIdle, StGap, StDesel};
      rsp_valid = (state_q == StDesel);
      rsp_err   = (state_q == StDesel) && err_q;
      rsp_rdata = rdata_q;
      sh_tx     = 8'h00;
      case (state_q)
         StWrenByte: sh_tx = CMD_WREN;
         StCmd:      sh_tx = write_q ? CMD_WRITE : CMD_READ;
         StA2:       sh_tx = addr_q[23:16];
         StA1:       sh_tx = addr_q[15:8];
         StA0:       sh_tx = addr_q[7:0];
         StData:     sh_tx = write_q ? wdata_q : 8'h00;
         default:    sh_tx = 8'h00;
      endcase
   end

endmodule
